// File: rtl/apb_cluster_seq_ctrl.sv
// APB control block for a set of clusters: power/reset/boot registers plus one
// power-up/down sequencer (pow -> rstn -> fetch_enable) per cluster.
module apb_cluster_seq_ctrl #(
   parameter int APB_ADDR_WIDTH = 12,
   parameter int NB_CLUSTERS    = 2,
   parameter int NB_CORES       = 8,
   parameter int PWR_DLY        = 16,
   parameter int RST_DLY        = 4
) (
   input  logic                         HCLK,
   input  logic                         HRESETn,
   input  logic [APB_ADDR_WIDTH-1:0]    PADDR,
   input  logic [31:0]                  PWDATA,
   input  logic                         PWRITE,
   input  logic                         PSEL,
   input  logic                         PENABLE,
   output logic [31:0]                  PRDATA,
   output logic                         PREADY,
   output logic                         PSLVERR,
   output logic [NB_CLUSTERS-1:0]       cluster_pow_o,
   output logic [NB_CLUSTERS-1:0]       cluster_rstn_o,
   output logic [NB_CLUSTERS-1:0]       cluster_fetch_enable_o,
   output logic [NB_CLUSTERS-1:0]       cluster_byp_o,
   output logic [64*NB_CLUSTERS-1:0]    cluster_boot_addr_o,
   output logic [NB_CLUSTERS-1:0]       cluster_irq_o,
   output logic                         seq_evt_o
);

   typedef enum logic [2:0] {ST_OFF, ST_PWR, ST_RST, ST_RUN, ST_DRAIN} seq_state_e;

   localparam logic [5:0]  PWR_LOAD = 6'(PWR_DLY - 1);
   localparam logic [5:0]  RST_LOAD = 6'(RST_DLY - 1);
   localparam logic [31:0] INFO_VAL = {16'(NB_CORES), 16'(NB_CLUSTERS)};

   seq_state_e                state_r [NB_CLUSTERS];
   logic [5:0]                cnt_r   [NB_CLUSTERS];
   logic [63:0]               boot_r  [NB_CLUSTERS];
   logic [NB_CLUSTERS-1:0]    pow_r, rstn_r, fetch_r, byp_r, irq_r;
   logic                      lock_r, evt_r;

   logic [5:0]                word_s;
   logic [3:0]                cl_off_s;
   logic [2:0]                cl_idx_s;
   logic [1:0]                cl_reg_s;
   logic                      cl_hit_s, cl_ok_s;
   logic [NB_CLUSTERS-1:0]    sel_s, run_s, busy_s, start_s, stop_s;
   logic                      sel_byp_s, sel_irq_s, sel_off_s, err_s, wr_s, evt_s;
   logic [63:0]               sel_boot_s;
   logic [31:0]               rdata_s;
   logic                      unused_s;

   assign word_s   = PADDR[7:2];
   assign cl_off_s = word_s[5:2] - 4'd4;
   assign cl_idx_s = cl_off_s[2:0];
   assign cl_reg_s = word_s[1:0];
   assign cl_hit_s = (word_s >= 6'd16) && (word_s <= 6'd47);
   assign cl_ok_s  = |sel_s;
   assign unused_s = ^{PADDR[APB_ADDR_WIDTH-1:8], PADDR[1:0]};

   // Per-cluster select and muxing of the selected cluster's fields
   always_comb begin
      sel_s      = {NB_CLUSTERS{1'b0}};
      run_s      = {NB_CLUSTERS{1'b0}};
      busy_s     = {NB_CLUSTERS{1'b0}};
      sel_byp_s  = 1'b0;
      sel_irq_s  = 1'b0;
      sel_off_s  = 1'b0;
      sel_boot_s = 64'd0;
      for (int c = 0; c < NB_CLUSTERS; c++) begin
         sel_s[c]   = cl_hit_s & (cl_idx_s == 3'(c));
         run_s[c]   = (state_r[c] == ST_RUN);
         busy_s[c]  = (state_r[c] == ST_PWR) | (state_r[c] == ST_RST) | (state_r[c] == ST_DRAIN);
         sel_byp_s  = sel_byp_s | (sel_s[c] & byp_r[c]);
         sel_irq_s  = sel_irq_s | (sel_s[c] & irq_r[c]);
         sel_off_s  = sel_off_s | (sel_s[c] & (state_r[c] == ST_OFF));
         sel_boot_s = sel_boot_s | ({64{sel_s[c]}} & boot_r[c]);
      end
   end

   // Read data and error decode; errors are only reported in the access phase
   always_comb begin
      rdata_s = 32'd0;
      err_s   = 1'b0;
      case (word_s)
         6'd0: begin rdata_s = INFO_VAL; err_s = PWRITE; end
         6'd1: rdata_s = {31'd0, lock_r};
         6'd2: begin rdata_s = {16'd0, 8'(busy_s), 8'(run_s)}; err_s = PWRITE; end
         default: begin
            if (!cl_ok_s) begin
               err_s = 1'b1;
            end else begin
               case (cl_reg_s)
                  2'd0: begin rdata_s = {29'd0, sel_byp_s, 2'd0}; err_s = PWRITE & lock_r; end
                  2'd1: begin rdata_s = sel_boot_s[31:0];  err_s = PWRITE & (lock_r | ~sel_off_s); end
                  2'd2: begin rdata_s = sel_boot_s[63:32]; err_s = PWRITE & (lock_r | ~sel_off_s); end
                  default: rdata_s = {31'd0, sel_irq_s};
               endcase
            end
         end
      endcase
   end

   assign wr_s    = PSEL & PENABLE & PWRITE & ~err_s;
   assign PSLVERR = PSEL & PENABLE & err_s;
   assign PRDATA  = rdata_s;
   assign PREADY  = 1'b1;

   // Command pulses and sequence-completion event (aborts never raise the event)
   always_comb begin
      start_s = {NB_CLUSTERS{1'b0}};
      stop_s  = {NB_CLUSTERS{1'b0}};
      evt_s   = 1'b0;
      for (int c = 0; c < NB_CLUSTERS; c++) begin
         start_s[c] = wr_s & sel_s[c] & (cl_reg_s == 2'd0) & PWDATA[0];
         stop_s[c]  = wr_s & sel_s[c] & (cl_reg_s == 2'd0) & PWDATA[1];
         evt_s = evt_s | ((state_r[c] == ST_RST) & (cnt_r[c] == 6'd0) & ~stop_s[c])
                       | ((state_r[c] == ST_DRAIN) & (cnt_r[c] == 6'd0));
      end
   end

   // Software-visible configuration registers
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         lock_r <= 1'b0;
         byp_r  <= {NB_CLUSTERS{1'b1}};
         irq_r  <= {NB_CLUSTERS{1'b0}};
         for (int c = 0; c < NB_CLUSTERS; c++) boot_r[c] <= 64'd0;
      end else begin
         if (wr_s && (word_s == 6'd1)) lock_r <= lock_r | PWDATA[0];
         for (int c = 0; c < NB_CLUSTERS; c++) begin
            if (wr_s && sel_s[c]) begin
               case (cl_reg_s)
                  2'd0:    byp_r[c]         <= PWDATA[2];
                  2'd1:    boot_r[c][31:0]  <= PWDATA;
                  2'd2:    boot_r[c][63:32] <= PWDATA;
                  default: irq_r[c]         <= PWDATA[0];
               endcase
            end
         end
      end
   end

   // Power sequencers with registered pow/rstn/fetch; STOP takes priority over START
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         pow_r   <= {NB_CLUSTERS{1'b0}};
         rstn_r  <= {NB_CLUSTERS{1'b0}};
         fetch_r <= {NB_CLUSTERS{1'b0}};
         evt_r   <= 1'b0;
         for (int c = 0; c < NB_CLUSTERS; c++) begin
            state_r[c] <= ST_OFF;
            cnt_r[c]   <= 6'd0;
         end
      end else begin
         evt_r <= evt_s;
         for (int c = 0; c < NB_CLUSTERS; c++) begin
            case (state_r[c])
               ST_OFF: begin
                  if (start_s[c] && !stop_s[c]) begin
                     state_r[c] <= ST_PWR;
                     cnt_r[c]   <= PWR_LOAD;
                     pow_r[c]   <= 1'b1;
                  end
               end
               ST_PWR, ST_RST: begin
                  if (stop_s[c]) begin
                     state_r[c] <= ST_OFF;
                     pow_r[c]   <= 1'b0;
                     rstn_r[c]  <= 1'b0;
                     fetch_r[c] <= 1'b0;
                  end else if (cnt_r[c] != 6'd0) begin
                     cnt_r[c] <= cnt_r[c] - 6'd1;
                  end else if (state_r[c] == ST_PWR) begin
                     state_r[c] <= ST_RST;
                     cnt_r[c]   <= RST_LOAD;
                     rstn_r[c]  <= 1'b1;
                  end else begin
                     state_r[c] <= ST_RUN;
                     fetch_r[c] <= 1'b1;
                  end
               end
               ST_RUN: begin
                  if (stop_s[c]) begin
                     state_r[c] <= ST_DRAIN;
                     cnt_r[c]   <= RST_LOAD;
                     rstn_r[c]  <= 1'b0;
                     fetch_r[c] <= 1'b0;
                  end
               end
               ST_DRAIN: begin
                  if (cnt_r[c] != 6'd0) begin
                     cnt_r[c] <= cnt_r[c] - 6'd1;
                  end else begin
                     state_r[c] <= ST_OFF;
                     pow_r[c]   <= 1'b0;
                  end
               end
               default: begin
                  state_r[c] <= ST_OFF;
                  pow_r[c]   <= 1'b0;
                  rstn_r[c]  <= 1'b0;
                  fetch_r[c] <= 1'b0;
               end
            endcase
         end
      end
   end

   assign cluster_pow_o          = pow_r;
   assign cluster_rstn_o         = rstn_r;
   assign cluster_fetch_enable_o = fetch_r;
   assign cluster_byp_o          = byp_r;
   assign cluster_irq_o          = irq_r;
   assign seq_evt_o              = evt_r;

   for (genvar g = 0; g < NB_CLUSTERS; g++) begin : g_boot
      assign cluster_boot_addr_o[64*g +: 64] = boot_r[g];
   end

endmodule

// File: tb/tb_apb_cluster_seq_ctrl.sv
// Directed bench for apb_cluster_seq_ctrl: register map, sequencer timing,
// access errors, lock behaviour and asynchronous reset mid-sequence.
module tb_apb_cluster_seq_ctrl;

   logic          HCLK = 1'b0;
   logic          HRESETn = 1'b0;
   logic [11:0]   PADDR = 12'd0;
   logic [31:0]   PWDATA = 32'd0;
   logic          PWRITE = 1'b0, PSEL = 1'b0, PENABLE = 1'b0;
   logic [31:0]   PRDATA;
   logic          PREADY, PSLVERR;
   logic [1:0]    pow, rstn, fetch, byp, irq;
   logic [127:0]  boot;
   logic          evt;

   int n_checks = 0;
   int n_fail   = 0;
   int evt_cnt  = 0;

   apb_cluster_seq_ctrl dut (
      .HCLK(HCLK), .HRESETn(HRESETn), .PADDR(PADDR), .PWDATA(PWDATA),
      .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE), .PRDATA(PRDATA),
      .PREADY(PREADY), .PSLVERR(PSLVERR), .cluster_pow_o(pow),
      .cluster_rstn_o(rstn), .cluster_fetch_enable_o(fetch), .cluster_byp_o(byp),
      .cluster_boot_addr_o(boot), .cluster_irq_o(irq), .seq_evt_o(evt)
   );

   always #5 HCLK = ~HCLK;

   always @(negedge HCLK) if (evt === 1'b1) evt_cnt++;

   task automatic tick();
      @(posedge HCLK); #1;
   endtask

   task automatic apb_write(input logic [11:0] a, input logic [31:0] d, output logic err);
      tick();
      PADDR = a; PWDATA = d; PWRITE = 1'b1; PSEL = 1'b1; PENABLE = 1'b0;
      tick();
      PENABLE = 1'b1; #3;
      err = PSLVERR;
      tick();
      PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
   endtask

   task automatic apb_read(input logic [11:0] a, output logic [31:0] d, output logic err);
      tick();
      PADDR = a; PWRITE = 1'b0; PSEL = 1'b1; PENABLE = 1'b0;
      tick();
      PENABLE = 1'b1; #3;
      d = PRDATA; err = PSLVERR;
      tick();
      PSEL = 1'b0; PENABLE = 1'b0;
   endtask

   task automatic test_reset();
      logic [31:0] d; logic e;
      HRESETn = 1'b0;
      repeat (3) tick();
      n_checks++; if ({pow, rstn, fetch} !== 6'b0) begin n_fail++; $display("FAIL reset_outs: got %b expected 000000", {pow, rstn, fetch}); end
      n_checks++; if (byp !== 2'b11) begin n_fail++; $display("FAIL reset_byp: got %b expected 11", byp); end
      n_checks++; if ({boot, irq, evt} !== 131'd0) begin n_fail++; $display("FAIL reset_boot_irq_evt: got nonzero"); end
      HRESETn = 1'b1;
      apb_read(12'h000, d, e);
      n_checks++; if (d !== 32'h0008_0002 || e !== 1'b0) begin n_fail++; $display("FAIL info_read: got %h/%b expected 00080002/0", d, e); end
      apb_read(12'h008, d, e);
      n_checks++; if (d !== 32'h0 || e !== 1'b0) begin n_fail++; $display("FAIL status_reset: got %h/%b expected 0/0", d, e); end
      apb_read(12'h040, d, e);
      n_checks++; if (d !== 32'h4) begin n_fail++; $display("FAIL ctrl_read_byp: got %h expected 00000004", d); end
      tick();
      PADDR = 12'h060; PSEL = 1'b1; PENABLE = 1'b0; #3;
      n_checks++; if (PSLVERR !== 1'b0) begin n_fail++; $display("FAIL slverr_setup_phase: got %b expected 0", PSLVERR); end
      PSEL = 1'b0;
   endtask

   task automatic test_start_stop();
      logic [31:0] d; logic e; int n; int e0;
      apb_write(12'h044, 32'h1C00_8080, e);
      n_checks++; if (e !== 1'b0 || boot[31:0] !== 32'h1C00_8080) begin n_fail++; $display("FAIL boot_lo_write: got %h/%b expected 1c008080/0", boot[31:0], e); end
      e0 = evt_cnt;
      apb_write(12'h040, 32'h1, e);
      n_checks++; if (pow[0] !== 1'b1 || rstn[0] !== 1'b0) begin n_fail++; $display("FAIL start_pow: got pow=%b rstn=%b expected 1/0", pow[0], rstn[0]); end
      n = 0; while (rstn[0] !== 1'b1 && n < 40) begin tick(); n++; end
      n_checks++; if (n !== 16) begin n_fail++; $display("FAIL pwr_delay: got %0d cycles expected 16", n); end
      n = 0; while (fetch[0] !== 1'b1 && n < 40) begin tick(); n++; end
      n_checks++; if (n !== 4) begin n_fail++; $display("FAIL rst_delay: got %0d cycles expected 4", n); end
      apb_read(12'h008, d, e);
      n_checks++; if (d !== 32'h1) begin n_fail++; $display("FAIL status_run: got %h expected 00000001", d); end
      n_checks++; if (evt_cnt - e0 !== 1) begin n_fail++; $display("FAIL evt_up: got %0d pulses expected 1", evt_cnt - e0); end
   endtask

   task automatic test_boot_protect_and_drain();
      logic e; int n; int e0;
      apb_write(12'h044, 32'hDEAD_BEEF, e);
      n_checks++; if (e !== 1'b1 || boot[31:0] !== 32'h1C00_8080) begin n_fail++; $display("FAIL boot_write_running: got %h/%b expected 1c008080/1", boot[31:0], e); end
      e0 = evt_cnt;
      apb_write(12'h040, 32'h2, e);
      n_checks++; if ({pow[0], rstn[0], fetch[0]} !== 3'b100) begin n_fail++; $display("FAIL stop_drain: got %b expected 100", {pow[0], rstn[0], fetch[0]}); end
      n = 0; while (pow[0] !== 1'b0 && n < 40) begin tick(); n++; end
      n_checks++; if (n !== 4) begin n_fail++; $display("FAIL drain_delay: got %0d cycles expected 4", n); end
      repeat (2) tick();
      n_checks++; if (evt_cnt - e0 !== 1) begin n_fail++; $display("FAIL evt_down: got %0d pulses expected 1", evt_cnt - e0); end
   endtask

   task automatic test_abort();
      logic [31:0] d; logic e; int n; int e0;
      e0 = evt_cnt;
      apb_write(12'h050, 32'h1, e);
      n_checks++; if (pow[1] !== 1'b1) begin n_fail++; $display("FAIL c1_start: got pow=%b expected 1", pow[1]); end
      repeat (2) tick();
      apb_write(12'h050, 32'h2, e);
      n_checks++; if ({pow[1], rstn[1], fetch[1]} !== 3'b000) begin n_fail++; $display("FAIL c1_abort: got %b expected 000", {pow[1], rstn[1], fetch[1]}); end
      n = 0;
      for (int i = 0; i < 25; i++) begin tick(); if (rstn[1] !== 1'b0 || pow[1] !== 1'b0) n++; end
      n_checks++; if (n !== 0) begin n_fail++; $display("FAIL c1_stays_off: got %0d bad cycles expected 0", n); end
      n_checks++; if (evt_cnt - e0 !== 0) begin n_fail++; $display("FAIL evt_abort: got %0d pulses expected 0", evt_cnt - e0); end
      apb_write(12'h050, 32'h3, e);
      apb_read(12'h008, d, e);
      n_checks++; if (pow[1] !== 1'b0 || d !== 32'h0) begin n_fail++; $display("FAIL start_stop_same: got pow=%b status=%h expected 0/0", pow[1], d); end
   endtask

   task automatic test_reset_mid_seq();
      logic [31:0] d; logic e; int n; int e0;
      apb_write(12'h040, 32'h1, e);
      apb_write(12'h050, 32'h1, e);
      repeat (2) tick();
      #2 HRESETn = 1'b0; #1;
      n_checks++; if ({pow, rstn, fetch, byp, evt} !== 9'b000000110) begin n_fail++; $display("FAIL async_reset: got %b expected 000000110", {pow, rstn, fetch, byp, evt}); end
      n_checks++; if (boot !== 128'd0) begin n_fail++; $display("FAIL async_reset_boot: got %h expected 0", boot); end
      repeat (2) tick();
      HRESETn = 1'b1;
      e0 = evt_cnt;
      apb_write(12'h050, 32'h1, e);
      n = 0; while (rstn[1] !== 1'b1 && n < 40) begin tick(); n++; end
      n_checks++; if (n !== 16) begin n_fail++; $display("FAIL restart_pwr_delay: got %0d expected 16", n); end
      n = 0; while (fetch[1] !== 1'b1 && n < 40) begin tick(); n++; end
      n_checks++; if (n !== 4) begin n_fail++; $display("FAIL restart_rst_delay: got %0d expected 4", n); end
      apb_write(12'h040, 32'h1, e);
      n = 0; while (fetch[0] !== 1'b1 && n < 60) begin tick(); n++; end
      n_checks++; if (n !== 20) begin n_fail++; $display("FAIL restart_c0_delay: got %0d expected 20", n); end
      apb_read(12'h008, d, e);
      n_checks++; if (d !== 32'h3) begin n_fail++; $display("FAIL status_both: got %h expected 00000003", d); end
      n_checks++; if (evt_cnt - e0 !== 2) begin n_fail++; $display("FAIL evt_restart: got %0d pulses expected 2", evt_cnt - e0); end
   endtask

   task automatic test_lock();
      logic [31:0] d; logic e;
      apb_write(12'h050, 32'h2, e);
      repeat (6) tick();
      apb_write(12'h004, 32'h1, e);
      n_checks++; if (e !== 1'b0) begin n_fail++; $display("FAIL lock_write: got err=%b expected 0", e); end
      apb_write(12'h050, 32'h1, e);
      tick();
      n_checks++; if (e !== 1'b1 || pow[1] !== 1'b0) begin n_fail++; $display("FAIL ctrl_locked: got err=%b pow=%b expected 1/0", e, pow[1]); end
      apb_write(12'h054, 32'h1234_5678, e);
      n_checks++; if (e !== 1'b1 || boot[95:64] !== 32'h0) begin n_fail++; $display("FAIL boot_locked: got err=%b val=%h expected 1/0", e, boot[95:64]); end
      apb_write(12'h04C, 32'h1, e);
      apb_read(12'h04C, d, e);
      n_checks++; if (irq !== 2'b01 || d !== 32'h1) begin n_fail++; $display("FAIL irq_rw: got irq=%b rd=%h expected 01/1", irq, d); end
      apb_write(12'h004, 32'h0, e);
      apb_read(12'h004, d, e);
      n_checks++; if (d !== 32'h1) begin n_fail++; $display("FAIL lock_sticky: got %h expected 00000001", d); end
      apb_read(12'h060, d, e);
      n_checks++; if (e !== 1'b1 || d !== 32'h0) begin n_fail++; $display("FAIL bad_cluster_read: got %h/%b expected 0/1", d, e); end
      apb_write(12'h000, 32'hFFFF_FFFF, e);
      n_checks++; if (e !== 1'b1) begin n_fail++; $display("FAIL ro_write: got err=%b expected 1", e); end
      apb_read(12'h00C, d, e);
      n_checks++; if (e !== 1'b1 || d !== 32'h0) begin n_fail++; $display("FAIL unmapped_read: got %h/%b expected 0/1", d, e); end
   endtask

   initial begin
      test_reset();
      test_start_stop();
      test_boot_protect_and_drain();
      test_abort();
      test_reset_mid_seq();
      test_lock();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
